// File: rtl/mem_stage.sv
// MiniCore MEM stage: branch resolution, data-memory access with ack timeout,
// and the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic [1:0]  wb_in,
  input  logic [2:0]  m_in,
  input  logic [31:0] branch_target,
  input  logic        alu_zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_in,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        mem_ready,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic [1:0]  wb_out,
  output logic [31:0] rdata_out,
  output logic [31:0] alu_out,
  output logic [4:0]  dest_out,
  output logic        bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      cap_q, cap_d;
  logic             bus_err_q, bus_err_d;
  logic             dmem_req_q, dmem_req_d;
  logic [1:0]       wb_q, wb_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      alu_q, alu_d;
  logic [4:0]       dest_q, dest_d;

  logic mem_op;
  logic misaligned;
  logic ready;
  logic adv;

  assign mem_op     = m_in[1] | m_in[0];
  assign misaligned = mem_op & (alu_result[1:0] != 2'b00);
  assign ready      = ((state_q == S_IDLE) & ~mem_op) | (state_q == S_DONE);
  assign adv        = ready & ~hold;

  // Next-state, access bookkeeping and MEM/WB load
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    bus_err_d = bus_err_q;
    wb_d      = wb_q;
    rdata_d   = rdata_q;
    alu_d     = alu_q;
    dest_d    = dest_q;

    case (state_q)
      S_IDLE: begin
        if (!hold && misaligned) begin
          state_d   = S_DONE;
          bus_err_d = 1'b1;
          cap_d     = 32'd0;
        end else if (!hold && mem_op) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
        end
      end
      S_ACCESS: begin
        // Ack has priority over the final timeout cycle
        if (dmem_ack) begin
          state_d = S_DONE;
          cap_d   = m_in[0] ? 32'd0 : dmem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          bus_err_d = 1'b1;
          cap_d     = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!hold) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    dmem_req_d = (state_d == S_ACCESS);

    if (adv) begin
      wb_d    = wb_in;
      alu_d   = alu_result;
      dest_d  = dest_in;
      rdata_d = (state_q == S_DONE) ? cap_q : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cap_q      <= 32'd0;
      bus_err_q  <= 1'b0;
      dmem_req_q <= 1'b0;
      wb_q       <= 2'd0;
      rdata_q    <= 32'd0;
      alu_q      <= 32'd0;
      dest_q     <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      bus_err_q  <= bus_err_d;
      dmem_req_q <= dmem_req_d;
      wb_q       <= wb_d;
      rdata_q    <= rdata_d;
      alu_q      <= alu_d;
      dest_q     <= dest_d;
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = m_in[0];
  assign dmem_addr  = alu_result;
  assign dmem_wdata = store_data;
  assign mem_ready  = ready;
  assign pc_src     = m_in[2] & alu_zero & adv;
  assign pc_target  = branch_target;
  assign wb_out     = wb_q;
  assign rdata_out  = rdata_q;
  assign alu_out    = alu_q;
  assign dest_out   = dest_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level reference model
// compared on every falling edge.
module tb_mem_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic [31:0] branch_target;
  logic        alu_zero;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dest_in;
  logic [31:0] dmem_rdata;
  logic        dmem_ack = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        mem_ready;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [1:0]  wb_out;
  logic [31:0] rdata_out;
  logic [31:0] alu_out;
  logic [4:0]  dest_out;
  logic        bus_err;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .hold(hold), .wb_in(wb_in), .m_in(m_in),
    .branch_target(branch_target), .alu_zero(alu_zero), .alu_result(alu_result),
    .store_data(store_data), .dest_in(dest_in), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .mem_ready(mem_ready),
    .pc_src(pc_src), .pc_target(pc_target), .wb_out(wb_out),
    .rdata_out(rdata_out), .alu_out(alu_out), .dest_out(dest_out),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks in the ack_k-th request cycle (0 = never)
  int ack_k  = 0;
  int resp_n = 0;
  always @(posedge clk) begin
    #1;
    if (dmem_req === 1'b1) begin
      resp_n++;
      dmem_ack = (ack_k != 0) && (resp_n == ack_k);
    end else begin
      resp_n   = 0;
      dmem_ack = 1'b0;
    end
  end

  // Reference model: one instruction at a time is either waiting on memory,
  // finished and waiting to retire, or not started.
  bit          m_busy, m_done, m_err;
  int          m_wait;
  logic [31:0] m_cap;
  logic [1:0]  e_wb;
  logic [31:0] e_rdata, e_alu;
  logic [4:0]  e_dest;

  function automatic bit model_ready();
    return m_done || (!m_busy && !(m_in[1] | m_in[0]));
  endfunction

  always @(posedge clk) begin
    bit adv;
    adv = model_ready() && !hold;
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_wait = 0; m_cap = 0;
      e_wb = 0; e_rdata = 0; e_alu = 0; e_dest = 0;
    end else begin
      if (adv) begin
        e_wb    = wb_in;
        e_alu   = alu_result;
        e_dest  = dest_in;
        e_rdata = m_done ? m_cap : 32'd0;
      end
      if (m_busy) begin
        m_wait++;
        if (dmem_ack) begin
          m_cap = m_in[0] ? 32'd0 : dmem_rdata;
          m_busy = 0; m_done = 1;
        end else if (m_wait == TIMEOUT) begin
          m_err = 1; m_cap = 0; m_busy = 0; m_done = 1;
        end
      end else if (m_done) begin
        if (!hold) m_done = 0;
      end else if (!hold && (m_in[1] | m_in[0])) begin
        if (alu_result[1:0] != 2'b00) begin
          m_err = 1; m_cap = 0; m_done = 1;
        end else begin
          m_busy = 1; m_wait = 0;
        end
      end
    end
  end

  bit          cmp_en = 0;
  int          req_cycles = 0;
  int          pc_cnt = 0;
  logic        seen_we;
  logic [31:0] seen_wdata;

  always @(negedge clk) begin
    if (cmp_en) begin
      bit rdy;
      rdy = model_ready();
      chk("dmem_req",   32'(dmem_req),   32'(m_busy));
      chk("mem_ready",  32'(mem_ready),  32'(rdy));
      chk("pc_src",     32'(pc_src),     32'(m_in[2] & alu_zero & rdy & !hold));
      chk("pc_target",  pc_target,       branch_target);
      chk("dmem_addr",  dmem_addr,       alu_result);
      chk("dmem_wdata", dmem_wdata,      store_data);
      chk("dmem_we",    32'(dmem_we),    32'(m_in[0]));
      chk("wb_out",     32'(wb_out),     32'(e_wb));
      chk("rdata_out",  rdata_out,       e_rdata);
      chk("alu_out",    alu_out,         e_alu);
      chk("dest_out",   32'(dest_out),   32'(e_dest));
      chk("bus_err",    32'(bus_err),    32'(m_err));
      if (dmem_req === 1'b1) begin
        req_cycles++;
        seen_we    = dmem_we;
        seen_wdata = dmem_wdata;
      end
      if (pc_src === 1'b1) pc_cnt++;
    end
  end

  task automatic set_op(input logic [2:0] m, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] dst, input logic [1:0] wb);
    m_in = m; alu_result = addr; store_data = wd; dest_in = dst; wb_in = wb;
  endtask

  task automatic filler();
    set_op(3'b000, 32'd0, 32'd0, 5'd0, 2'b10);
    alu_zero = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; alu_zero = 1'b0; branch_target = 32'd0; dmem_rdata = 32'd0;
    set_op(3'b000, 32'd0, 32'd0, 5'd0, 2'b00);
    tick();
    cmp_en = 1;
    tick();
    chk("reset dmem_req", 32'(dmem_req), 32'd0);
    chk("reset alu_out", alu_out, 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    chk("reset pc_src", 32'(pc_src), 32'd0);
    rst = 1'b0;

    // Non-memory instruction retires immediately
    req_cycles = 0;
    set_op(3'b000, 32'h1234, 32'd0, 5'd5, 2'b10);
    #1 chk("nonmem mem_ready", 32'(mem_ready), 32'd1);
    tick();
    chk("nonmem alu_out", alu_out, 32'h1234);
    chk("nonmem dest_out", 32'(dest_out), 32'd5);
    chk("nonmem rdata_out", rdata_out, 32'd0);
    chk("nonmem req_cycles", 32'(req_cycles), 32'd0);

    // Load acked in the 2nd access cycle
    req_cycles = 0; ack_k = 2; dmem_rdata = 32'hDEADBEEF;
    set_op(3'b010, 32'h40, 32'd0, 5'd7, 2'b11);
    tick(); tick(); tick();
    chk("load done mem_ready", 32'(mem_ready), 32'd1);
    tick();
    filler();
    chk("load rdata_out", rdata_out, 32'hDEADBEEF);
    chk("load dest_out", 32'(dest_out), 32'd7);
    chk("load req_cycles", 32'(req_cycles), 32'd2);
    chk("load we", 32'(seen_we), 32'd0);
    tick();

    // Store with immediate ack, held in DONE for 3 cycles
    req_cycles = 0; ack_k = 1; dmem_rdata = 32'h11111111;
    set_op(3'b001, 32'h80, 32'hA5A5A5A5, 5'd9, 2'b00);
    tick();
    hold = 1'b1;
    tick(); tick(); tick();
    chk("store held alu_out", alu_out, 32'd0);
    tick();
    hold = 1'b0;
    chk("store held2 alu_out", alu_out, 32'd0);
    tick();
    filler();
    chk("store alu_out", alu_out, 32'h80);
    chk("store rdata_out", rdata_out, 32'd0);
    chk("store req_cycles", 32'(req_cycles), 32'd1);
    chk("store we", 32'(seen_we), 32'd1);
    chk("store wdata", seen_wdata, 32'hA5A5A5A5);
    tick();

    // Ack on the last permitted cycle wins over timeout
    req_cycles = 0; ack_k = TIMEOUT; dmem_rdata = 32'h0BADF00D;
    set_op(3'b010, 32'hC0, 32'd0, 5'd4, 2'b11);
    repeat (TIMEOUT + 2) tick();
    filler();
    chk("lateack rdata_out", rdata_out, 32'h0BADF00D);
    chk("lateack bus_err", 32'(bus_err), 32'd0);
    chk("lateack req_cycles", 32'(req_cycles), 32'd16);
    tick();

    // Timeout with no ack
    req_cycles = 0; ack_k = 0; dmem_rdata = 32'hFFFFFFFF;
    set_op(3'b010, 32'h100, 32'd0, 5'd3, 2'b11);
    repeat (TIMEOUT + 2) tick();
    filler();
    chk("timeout req_cycles", 32'(req_cycles), 32'd16);
    chk("timeout bus_err", 32'(bus_err), 32'd1);
    chk("timeout rdata_out", rdata_out, 32'd0);
    chk("timeout alu_out", alu_out, 32'h100);
    tick();

    // Misaligned load: no request, retires in 2 cycles
    req_cycles = 0;
    set_op(3'b010, 32'h42, 32'd0, 5'd6, 2'b11);
    tick();
    chk("misal mem_ready", 32'(mem_ready), 32'd1);
    tick();
    filler();
    chk("misal alu_out", alu_out, 32'h42);
    chk("misal rdata_out", rdata_out, 32'd0);
    chk("misal req_cycles", 32'(req_cycles), 32'd0);
    chk("misal bus_err", 32'(bus_err), 32'd1);
    tick();

    // Taken branch, first stalled by hold
    pc_cnt = 0;
    set_op(3'b100, 32'd0, 32'd0, 5'd0, 2'b00);
    alu_zero = 1'b1; branch_target = 32'h100; hold = 1'b1;
    #1 chk("branch held pc_src", 32'(pc_src), 32'd0);
    tick();
    hold = 1'b0;
    #1 chk("branch pc_src", 32'(pc_src), 32'd1);
    chk("branch pc_target", pc_target, 32'h100);
    tick();
    filler();
    tick();
    chk("branch pc_cnt", 32'(pc_cnt), 32'd1);
    set_op(3'b100, 32'd0, 32'd0, 5'd0, 2'b00);
    alu_zero = 1'b0;
    #1 chk("branch nz pc_src", 32'(pc_src), 32'd0);
    tick();
    filler();
    tick();

    // Reset during the 3rd access cycle
    ack_k = 0;
    set_op(3'b010, 32'h200, 32'd0, 5'd2, 2'b11);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    filler();
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    chk("rst alu_out", alu_out, 32'd0);
    chk("rst dest_out", 32'(dest_out), 32'd0);
    chk("rst wb_out", 32'(wb_out), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    rst = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
